// File: rtl/clk_mgmt_pkg.sv
// Shared types and constants for the MMCM DRP / phase-shift responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_mgmt_pkg;

  localparam int DRP_ADDR_W      = 7;
  localparam int DRP_DATA_W      = 16;
  localparam int DRP_DEPTH       = 128;
  localparam int PS_PHASE_W      = 9;

  localparam int DEF_DRP_LATENCY = 4;
  localparam int DEF_PS_LATENCY  = 12;
  localparam int DEF_PS_PERIOD   = 448;   // 56 steps x VCO/out ratio of 8
  localparam int DEF_LOCK_CYCLES = 64;

  typedef enum logic {
    DRP_IDLE = 1'b0,
    DRP_BUSY = 1'b1
  } drp_state_e;

  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_BUSY = 1'b1
  } ps_state_e;

  // One fine phase step with wrap-around in both directions.
  function automatic logic [PS_PHASE_W-1:0] ps_next_phase(
    input logic [PS_PHASE_W-1:0] phase,
    input logic                  inc,
    input int                    period
  );
    logic [PS_PHASE_W-1:0] last;
    last = PS_PHASE_W'(period - 1);
    if (inc) return (phase == last) ? '0 : phase + 1'b1;
    else     return (phase == '0)   ? last : phase - 1'b1;
  endfunction

endpackage

// File: rtl/mmcm_ps_engine.sv
// MMCM fine phase-shift engine: accumulates psincdec steps into a wrapping phase.
// Latency: ps_en_i at cycle T -> ps_done_o and updated ps_phase_o at T+pPS_LATENCY.
// Backpressure: none; requests while busy or unlocked are dropped and flagged in ps_err_o.
// Ports: clk_i/rst_n_i (sync active-low), ps_en_i/ps_incdec_i request, locked_i gate,
//        abort_i (MMCM RST) kills an in-flight step and zeroes the phase,
//        ps_done_o pulse, ps_phase_o accumulator, ps_err_o sticky reject flag.
module mmcm_ps_engine
  import clk_mgmt_pkg::*;
#(
  parameter int pPS_LATENCY = DEF_PS_LATENCY,
  parameter int pPS_PERIOD  = DEF_PS_PERIOD
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ps_en_i,
  input  logic                  ps_incdec_i,
  input  logic                  locked_i,
  input  logic                  abort_i,
  output logic                  ps_done_o,
  output logic [PS_PHASE_W-1:0] ps_phase_o,
  output logic                  ps_err_o
);

  localparam int CW = 5;  // covers latencies up to 31

  ps_state_e             state_q;
  logic [CW-1:0]         cnt_q;
  logic                  inc_q;
  logic                  done_q;
  logic                  err_q;
  logic [PS_PHASE_W-1:0] phase_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        // MMCM held in reset: drop any in-flight step without a done pulse.
        state_q <= PS_IDLE;
        cnt_q   <= '0;
        phase_q <= '0;
        if (ps_en_i) err_q <= 1'b1;
      end else begin
        case (state_q)
          PS_IDLE: begin
            if (ps_en_i) begin
              if (!locked_i) begin
                err_q <= 1'b1;
              end else if (pPS_LATENCY == 1) begin
                done_q  <= 1'b1;
                phase_q <= ps_next_phase(phase_q, ps_incdec_i, pPS_PERIOD);
              end else begin
                // Counter holds latency-1 so the done pulse lands on T+latency.
                inc_q   <= ps_incdec_i;
                cnt_q   <= CW'(pPS_LATENCY - 1);
                state_q <= PS_BUSY;
              end
            end
          end
          PS_BUSY: begin
            if (ps_en_i) err_q <= 1'b1;
            if (cnt_q == CW'(1)) begin
              done_q  <= 1'b1;
              phase_q <= ps_next_phase(phase_q, inc_q, pPS_PERIOD);
              state_q <= PS_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= PS_IDLE;
        endcase
      end
    end
  end

  assign ps_done_o  = done_q;
  assign ps_phase_o = phase_q;
  assign ps_err_o   = err_q;

endmodule

// File: rtl/mmcm_drp_ps_responder.sv
// MMCM stand-in: DRP register image (128x16), fine phase-shift port and lock model.
// Latency: drp_den_i -> drp_drdy_o after pDRP_LATENCY; ps_en_i -> ps_done_o after pPS_LATENCY.
// Backpressure: none; requests while busy are dropped and flagged in sticky error bits.
// Ports: clk_usb_i/reset_n_i (sync active-low); drp_* DRP port (DCLK = clk_usb_i);
//        ps_* phase-shift port (PSCLK = clk_usb_i); lock_reset_i models RST, locked_o LOCKED;
//        drp_err_o / ps_err_o sticky reject flags. All outputs are registered.
module mmcm_drp_ps_responder
  import clk_mgmt_pkg::*;
#(
  parameter int pDRP_LATENCY = DEF_DRP_LATENCY,
  parameter int pPS_LATENCY  = DEF_PS_LATENCY,
  parameter int pPS_PERIOD   = DEF_PS_PERIOD,
  parameter int pLOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk_usb_i,
  input  logic                  reset_n_i,
  input  logic [DRP_ADDR_W-1:0] drp_addr_i,
  input  logic                  drp_den_i,
  input  logic                  drp_dwe_i,
  input  logic [DRP_DATA_W-1:0] drp_din_i,
  output logic [DRP_DATA_W-1:0] drp_dout_o,
  output logic                  drp_drdy_o,
  input  logic                  ps_en_i,
  input  logic                  ps_incdec_i,
  output logic                  ps_done_o,
  output logic [PS_PHASE_W-1:0] ps_phase_o,
  input  logic                  lock_reset_i,
  output logic                  locked_o,
  output logic                  drp_err_o,
  output logic                  ps_err_o
);

  localparam int DCW = 4;                          // covers DRP latencies up to 15
  localparam int LCW = $clog2(pLOCK_CYCLES + 1);

  // ---------------- DRP port ----------------
  drp_state_e                            drp_state_q;
  logic [DCW-1:0]                        drp_cnt_q;
  logic [DRP_DEPTH-1:0][DRP_DATA_W-1:0]  image_q;
  logic [DRP_DATA_W-1:0]                 rd_dat_q;
  logic [DRP_DATA_W-1:0]                 dout_q;
  logic                                  drdy_q;
  logic                                  drp_err_q;

  always_ff @(posedge clk_usb_i) begin
    if (!reset_n_i) begin
      drp_state_q <= DRP_IDLE;
      drp_cnt_q   <= '0;
      image_q     <= '0;
      rd_dat_q    <= '0;
      dout_q      <= '0;
      drdy_q      <= 1'b0;
      drp_err_q   <= 1'b0;
    end else begin
      drdy_q <= 1'b0;
      dout_q <= '0;
      case (drp_state_q)
        DRP_IDLE: begin
          if (drp_den_i) begin
            // Write commits and read samples in the accept cycle, so a later
            // read always observes every earlier accepted write.
            if (drp_dwe_i) image_q[drp_addr_i] <= drp_din_i;
            if (pDRP_LATENCY == 1) begin
              drdy_q <= 1'b1;
              dout_q <= drp_dwe_i ? '0 : image_q[drp_addr_i];
            end else begin
              rd_dat_q    <= drp_dwe_i ? '0 : image_q[drp_addr_i];
              drp_cnt_q   <= DCW'(pDRP_LATENCY - 1);
              drp_state_q <= DRP_BUSY;
            end
          end
        end
        DRP_BUSY: begin
          if (drp_den_i) drp_err_q <= 1'b1;
          if (drp_cnt_q == DCW'(1)) begin
            // Returning to IDLE here lets a den coincident with drdy be accepted.
            drdy_q      <= 1'b1;
            dout_q      <= rd_dat_q;
            drp_state_q <= DRP_IDLE;
          end else begin
            drp_cnt_q <= drp_cnt_q - 1'b1;
          end
        end
        default: drp_state_q <= DRP_IDLE;
      endcase
    end
  end

  // ---------------- Lock model ----------------
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (lock_reset_i) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (!locked_q) begin
      // Counts clean cycles; the pLOCK_CYCLES-th one raises locked.
      if (lock_cnt_q == LCW'(pLOCK_CYCLES - 1)) locked_d   = 1'b1;
      else                                      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_usb_i) begin
    if (!reset_n_i) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // ---------------- Phase shift ----------------
  mmcm_ps_engine #(
    .pPS_LATENCY (pPS_LATENCY),
    .pPS_PERIOD  (pPS_PERIOD)
  ) u_ps (
    .clk_i       (clk_usb_i),
    .rst_n_i     (reset_n_i),
    .ps_en_i     (ps_en_i),
    .ps_incdec_i (ps_incdec_i),
    .locked_i    (locked_q),
    .abort_i     (lock_reset_i),
    .ps_done_o   (ps_done_o),
    .ps_phase_o  (ps_phase_o),
    .ps_err_o    (ps_err_o)
  );

  assign drp_dout_o = dout_q;
  assign drp_drdy_o = drdy_q;
  assign drp_err_o  = drp_err_q;
  assign locked_o   = locked_q;

endmodule

// File: tb/tb_mmcm_drp_ps_responder.sv
module tb_mmcm_drp_ps_responder;

  localparam int L_DRP  = 4;
  localparam int L_PS   = 12;
  localparam int PERIOD = 448;
  localparam int LOCKC  = 64;
  localparam int NEVER  = 32'h7fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n    = 1'b0;
  logic [6:0]  drp_addr   = '0;
  logic        drp_den    = 1'b0;
  logic        drp_dwe    = 1'b0;
  logic [15:0] drp_din    = '0;
  logic        ps_en      = 1'b0;
  logic        ps_incdec  = 1'b0;
  logic        lock_reset = 1'b0;
  logic [15:0] drp_dout;
  logic        drp_drdy;
  logic        ps_done;
  logic [8:0]  ps_phase;
  logic        locked;
  logic        drp_err;
  logic        ps_err;

  mmcm_drp_ps_responder dut (
    .clk_usb_i    (clk),
    .reset_n_i    (reset_n),
    .drp_addr_i   (drp_addr),
    .drp_den_i    (drp_den),
    .drp_dwe_i    (drp_dwe),
    .drp_din_i    (drp_din),
    .drp_dout_o   (drp_dout),
    .drp_drdy_o   (drp_drdy),
    .ps_en_i      (ps_en),
    .ps_incdec_i  (ps_incdec),
    .ps_done_o    (ps_done),
    .ps_phase_o   (ps_phase),
    .lock_reset_i (lock_reset),
    .locked_o     (locked),
    .drp_err_o    (drp_err),
    .ps_err_o     (ps_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    int dat;
  } exp_t;

  exp_t        drp_q[$];
  exp_t        ps_q[$];

  // Reference model state
  logic [15:0] img [128];
  int          drp_free = 0;
  int          ps_free  = 0;
  int          lock_ok  = NEVER;
  int          phase    = 0;
  bit          exp_drp_err = 1'b0;
  bit          exp_ps_err  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT signals completion.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (drp_drdy === 1'b1) begin
        if (drp_q.size() == 0) check("drdy_unexpected", 1, 0);
        else begin
          e = drp_q.pop_front();
          check("drdy_cycle", cyc, e.cyc);
          check("drdy_dout", {16'h0, drp_dout}, e.dat);
        end
      end else begin
        check("dout_idle_zero", {16'h0, drp_dout}, 0);
        if (drp_q.size() > 0 && drp_q[0].cyc <= cyc) begin
          check("drdy_missing", 0, 1);
          void'(drp_q.pop_front());
        end
      end
      if (ps_done === 1'b1) begin
        if (ps_q.size() == 0) check("ps_done_unexpected", 1, 0);
        else begin
          e = ps_q.pop_front();
          check("ps_done_cycle", cyc, e.cyc);
          check("ps_done_phase", {23'h0, ps_phase}, e.dat);
        end
      end else if (ps_q.size() > 0 && ps_q[0].cyc <= cyc) begin
        check("ps_done_missing", 0, 1);
        void'(ps_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    drp_den = 1'b0;
    ps_en   = 1'b0;
  endtask

  task automatic drp_req(input logic [6:0] a, input logic we, input logic [15:0] d);
    exp_t e;
    drp_den = 1'b1; drp_addr = a; drp_dwe = we; drp_din = d;
    if (cyc >= drp_free) begin
      if (we) begin img[a] = d; e.dat = 0; end
      else e.dat = int'(img[a]);
      e.cyc    = cyc + L_DRP;
      drp_free = cyc + L_DRP;
      drp_q.push_back(e);
    end else begin
      exp_drp_err = 1'b1;
    end
  endtask

  task automatic ps_req(input logic inc);
    exp_t e;
    ps_en = 1'b1; ps_incdec = inc;
    if (cyc >= lock_ok && cyc >= ps_free && !lock_reset) begin
      phase   = inc ? (phase + 1) % PERIOD : (phase + PERIOD - 1) % PERIOD;
      e.cyc   = cyc + L_PS;
      e.dat   = phase;
      ps_free = cyc + L_PS;
      ps_q.push_back(e);
    end else begin
      exp_ps_err = 1'b1;
    end
  endtask

  // Completions due after cycle x are cancelled by a reset/abort seen at the end of x.
  task automatic purge_drp(input int x);
    while (drp_q.size() > 0 && drp_q[$].cyc > x) void'(drp_q.pop_back());
  endtask

  task automatic purge_ps(input int x);
    while (ps_q.size() > 0 && ps_q[$].cyc > x) void'(ps_q.pop_back());
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    purge_drp(cyc);
    purge_ps(cyc);
    for (int i = 0; i < 128; i++) img[i] = '0;
    drp_free = 0; ps_free = 0; phase = 0;
    exp_drp_err = 1'b0; exp_ps_err = 1'b0;
    lock_ok = NEVER;
    repeat (n) step();
    reset_n = 1'b1;
    lock_ok = cyc + LOCKC;
  endtask

  task automatic pulse_lock_reset();
    lock_reset = 1'b1;
    purge_ps(cyc);
    phase = 0; ps_free = 0; lock_ok = NEVER;
    step();
    lock_reset = 1'b0;
    lock_ok = cyc + LOCKC;
  endtask

  initial begin
    int r;
    int z;
    for (int i = 0; i < 128; i++) img[i] = '0;

    do_reset(3);
    r = cyc;
    check("rst_drdy", drp_drdy, 0);
    check("rst_dout", drp_dout, 0);
    check("rst_ps_done", ps_done, 0);
    check("rst_ps_phase", ps_phase, 0);
    check("rst_locked", locked, 0);
    check("rst_drp_err", drp_err, 0);
    check("rst_ps_err", ps_err, 0);

    // Phase step before lock is rejected
    ps_req(1'b1);
    step();
    check("ps_err_unlocked", ps_err, 1);
    step();
    check("phase_unlocked", ps_phase, 0);

    // Write then read-back, then untouched address
    drp_req(7'h08, 1'b1, 16'h1234);
    repeat (L_DRP) step();
    drp_req(7'h08, 1'b0, 16'h0);
    repeat (L_DRP) step();
    drp_req(7'h09, 1'b0, 16'h0);
    repeat (L_DRP + 1) step();
    check("drp_err_clean", drp_err, 0);

    // Overlapping requests: middle one dropped
    drp_req(7'h03, 1'b1, 16'hBEEF);
    repeat (2) step();
    drp_req(7'h04, 1'b1, 16'h5555);
    repeat (2) step();
    drp_req(7'h03, 1'b0, 16'h0);
    step();
    check("drp_err_busy", drp_err, 1);
    repeat (L_DRP) step();
    drp_req(7'h04, 1'b0, 16'h0);
    repeat (L_DRP + 1) step();

    // Lock timing after reset release
    while (cyc < r + LOCKC - 1) step();
    check("locked_before", locked, 0);
    step();
    check("locked_after", locked, 1);

    repeat (3) begin ps_req(1'b1); repeat (L_PS) step(); end
    step();
    check("phase_after_inc", ps_phase, 3);
    repeat (4) begin ps_req(1'b0); repeat (L_PS) step(); end
    step();
    check("phase_after_dec", ps_phase, 447);

    // Reset during DRP busy
    drp_req(7'h08, 1'b0, 16'h0);
    repeat (2) step();
    do_reset(2);
    check("rst2_drp_err", drp_err, 0);
    check("rst2_ps_err", ps_err, 0);
    check("rst2_phase", ps_phase, 0);
    drp_req(7'h08, 1'b0, 16'h0);
    repeat (L_DRP + 1) step();

    while (cyc < lock_ok) step();
    check("relocked", locked, 1);

    // Phase step while busy is rejected
    ps_req(1'b1);
    repeat (3) step();
    ps_req(1'b1);
    step();
    check("ps_err_busy", ps_err, 1);
    repeat (L_PS) step();

    // Lock reset aborts an in-flight step; concurrent DRP read still completes
    ps_req(1'b1);
    repeat (6) step();
    drp_req(7'h08, 1'b0, 16'h0);
    pulse_lock_reset();
    z = cyc;
    check("phase_abort", ps_phase, 0);
    check("locked_drop", locked, 0);
    while (cyc < z + LOCKC - 1) step();
    check("locked_before_relock", locked, 0);
    step();
    check("locked_relock", locked, 1);

    // Randomized traffic against the model
    repeat (600) begin
      step();
      if ($urandom_range(0, 2) == 0)
        drp_req(7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 4) == 0)
        ps_req(1'($urandom_range(0, 1)));
    end
    repeat (L_PS + 4) step();

    check("drp_queue_drained", drp_q.size(), 0);
    check("ps_queue_drained", ps_q.size(), 0);
    check("final_drp_err", drp_err, exp_drp_err);
    check("final_ps_err", ps_err, exp_ps_err);
    check("final_phase", ps_phase, phase);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
